// File: rtl/zuart_pkg.sv
// Shared types and constants for the zuart receive path.
package zuart_pkg;

    localparam int unsigned DEF_CLK_DIV = 1157;  // 133333333 / 115200
    localparam int unsigned CNT_W       = 11;
    localparam int unsigned DATA_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_e;

endpackage

// File: rtl/zuart_receiver_if.sv
// Receive-side result bus of zuart_receiver: byte, strobes and busy flag.
interface zuart_receiver_if;
    import zuart_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              brk;
    logic              parity_err;
    logic              busy;

    modport master (
        output rx_data, rx_valid, frame_err, brk, parity_err, busy
    );

    modport slave (
        input rx_data, rx_valid, frame_err, brk, parity_err, busy
    );

endinterface

// File: rtl/zuart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line; resets to the idle (high) level.
module zuart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    output logic rxs
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/zuart_receiver.sv
// UART receiver, 8-N-1 LSB first; define UART_PARITY_EN for 8-E-1 with a parity_err strobe.
module zuart_receiver
    import zuart_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rx_pin,
    zuart_receiver_if.master rx_if
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

    logic rxs;

    zuart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_pin(rx_pin),
        .rxs   (rxs)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        flush_q, flush_d;
    logic              armed_q, armed_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              brk_q, brk_d;
`ifdef UART_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    // rxs only counts as "seen high" once the synchronizer holds real line samples.
    assign flush_d = (flush_q == 2'(SYNC_STAGES)) ? flush_q : flush_q + 2'd1;
    assign armed_d = armed_q | (rxs & (flush_q == 2'(SYNC_STAGES)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en && armed_q && !rxs) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        idx_d = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rxs;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        par_d   = rxs;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leaving mid stop bit lets a back-to-back start edge be caught.
                    if (cnt_q == FULL_M1) begin
                        cnt_d = '0;
`ifdef UART_PARITY_EN
                        perr_d = ^{shift_q, par_q};
`endif
                        if (rxs) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            brk_d   = (shift_q == '0);
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            flush_q <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flush_q <= flush_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.brk       = brk_q;
    assign rx_if.busy      = (state_q != IDLE);
`ifdef UART_PARITY_EN
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_zuart_receiver.sv
// Self-checking bench for zuart_receiver with CLK_DIV=16 and a 10 ns clock.
`timescale 1ns/1ps
module tb_zuart_receiver;

    localparam int unsigned CLK_DIV     = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam real         BIT_NS      = 160.0;
`ifdef UART_PARITY_EN
    localparam int LAT = SYNC_STAGES + CLK_DIV / 2 + 10 * CLK_DIV + 1;
`else
    localparam int LAT = SYNC_STAGES + CLK_DIV / 2 + 9 * CLK_DIV + 1;
`endif

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b1;
    logic rx_pin = 1'b1;

    zuart_receiver_if bus ();

    zuart_receiver #(
        .CLK_DIV    (CLK_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .rx_pin(rx_pin),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log of DUT outputs, sampled mid-cycle.
    int         n_valid = 0, n_ferr = 0, n_brk = 0, n_fb = 0, n_perr = 0, n_vp = 0, n_busy = 0;
    int         last_valid_cyc = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid++;
            got_q.push_back(bus.rx_data);
            last_valid_cyc = cyc;
        end
        if (bus.frame_err) n_ferr++;
        if (bus.brk) n_brk++;
        if (bus.frame_err && bus.brk) n_fb++;
        if (bus.parity_err) n_perr++;
        if (bus.rx_valid && bus.parity_err) n_vp++;
        if (bus.busy) n_busy++;
    end

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start, 8 data LSB first, optional parity, stop; line left high afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              input real bit_t);
        rx_pin = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            #(bit_t);
        end
`ifdef UART_PARITY_EN
        rx_pin = par_bit;
        #(bit_t);
`endif
        rx_pin = stop_bit;
        #(bit_t);
        rx_pin = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %0h want 00", bus.rx_data);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy);
        end
        total++;
        if ({bus.rx_valid, bus.frame_err, bus.brk, bus.parity_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %0b%0b%0b%0b want 0000", bus.rx_valid,
                            bus.frame_err, bus.brk, bus.parity_err);
        end
        rst = 1'b0;
        idle(8);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL idle_busy: got %0b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int v0, e0, t0;
        logic [7:0] d;
        d = 8'hA5;
        v0 = n_valid; e0 = n_ferr + n_brk + n_perr;
        @(negedge clk);
        t0 = cyc;
        send_frame(d, 1'b1, even_par(d), BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_valid - v0 != 1) begin
            bad++; $display("FAIL basic_count: got %0d want 1", n_valid - v0);
        end
        total++;
        if (bus.rx_data !== 8'hA5) begin
            bad++; $display("FAIL basic_data: got %0h want a5", bus.rx_data);
        end
        total++;
        if (n_ferr + n_brk + n_perr - e0 != 0) begin
            bad++; $display("FAIL basic_errs: got %0d want 0", n_ferr + n_brk + n_perr - e0);
        end
        total++;
        if (last_valid_cyc - t0 != LAT) begin
            bad++; $display("FAIL basic_latency: got %0d want %0d", last_valid_cyc - t0, LAT);
        end
    endtask

    task automatic test_glitch();
        int b0, s0, db;
        s0 = n_valid + n_ferr + n_brk + n_perr;
        @(negedge clk);
        b0 = n_busy;
        rx_pin = 1'b0;
        idle(4);
        rx_pin = 1'b1;
        idle(3 * CLK_DIV);
        db = n_busy - b0;
        total++;
        if (!(db >= 1 && db <= 8)) begin
            bad++; $display("FAIL glitch_busy: got %0d cycles want 1..8", db);
        end
        total++;
        if (n_valid + n_ferr + n_brk + n_perr - s0 != 0) begin
            bad++; $display("FAIL glitch_strobes: got %0d want 0",
                            n_valid + n_ferr + n_brk + n_perr - s0);
        end
        total++;
        if (bus.rx_data !== 8'hA5) begin
            bad++; $display("FAIL glitch_data: got %0h want a5", bus.rx_data);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0, b0;
        logic [7:0] d;
        d = 8'h3C;
        v0 = n_valid; f0 = n_ferr; b0 = n_brk;
        @(negedge clk);
        send_frame(d, 1'b0, even_par(d), BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_ferr - f0 != 1) begin
            bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0);
        end
        total++;
        if (n_brk - b0 != 0 || n_valid - v0 != 0) begin
            bad++; $display("FAIL ferr_others: got brk=%0d valid=%0d want 0 0", n_brk - b0,
                            n_valid - v0);
        end
        total++;
        if (bus.rx_data !== 8'hA5) begin
            bad++; $display("FAIL ferr_data: got %0h want a5", bus.rx_data);
        end
        d = 8'h5A;
        send_frame(d, 1'b1, even_par(d), BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_valid - v0 != 1 || bus.rx_data !== 8'h5A) begin
            bad++; $display("FAIL ferr_recover: got n=%0d data=%0h want 1 5a", n_valid - v0,
                            bus.rx_data);
        end
    endtask

    task automatic test_break();
        int v0, f0, b0, fb0;
        logic [7:0] d;
        v0 = n_valid; f0 = n_ferr; b0 = n_brk; fb0 = n_fb;
        @(negedge clk);
        rx_pin = 1'b0;
        #(12.0 * BIT_NS);
        total++;
        if (n_valid - v0 != 0) begin
            bad++; $display("FAIL brk_valid_low: got %0d want 0", n_valid - v0);
        end
        rx_pin = 1'b1;
        idle(2 * CLK_DIV);
        total++;
        if (n_fb - fb0 != 1 || n_ferr - f0 != 1 || n_brk - b0 != 1) begin
            bad++; $display("FAIL brk_count: got both=%0d ferr=%0d brk=%0d want 1 1 1",
                            n_fb - fb0, n_ferr - f0, n_brk - b0);
        end
        d = 8'h81;
        send_frame(d, 1'b1, even_par(d), BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_valid - v0 != 1 || bus.rx_data !== 8'h81) begin
            bad++; $display("FAIL brk_recover: got n=%0d data=%0h want 1 81", n_valid - v0,
                            bus.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        real scale[2];
        scale[0] = 1.03;
        scale[1] = 0.97;
        for (int s = 0; s < 2; s++) begin
            int v0, q0;
            logic [7:0] b0, b1;
            v0 = n_valid; q0 = got_q.size();
            @(negedge clk);
            send_frame(8'h00, 1'b1, 1'b0, BIT_NS * scale[s]);
            send_frame(8'hFF, 1'b1, 1'b0, BIT_NS * scale[s]);
            idle(2 * CLK_DIV);
            b0 = (got_q.size() > q0) ? got_q[q0] : 8'hxx;
            b1 = (got_q.size() > q0 + 1) ? got_q[q0+1] : 8'hxx;
            total++;
            if (n_valid - v0 != 2) begin
                bad++; $display("FAIL b2b_count[%0d]: got %0d want 2", s, n_valid - v0);
            end
            total++;
            if (b0 !== 8'h00 || b1 !== 8'hFF) begin
                bad++; $display("FAIL b2b_order[%0d]: got %0h %0h want 00 ff", s, b0, b1);
            end
        end
    endtask

    task automatic test_random();
        int v0, f0, b0, p0, q0;
        int ex_ferr, ex_brk, ex_perr, mism;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic ok, pb;
        v0 = n_valid; f0 = n_ferr; b0 = n_brk; p0 = n_perr; q0 = got_q.size();
        ex_ferr = 0; ex_brk = 0; ex_perr = 0; mism = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(3) != 0);
            pb = even_par(d) ^ ($urandom_range(4) == 0);
            if (ok) exp_q.push_back(d);
            else begin
                ex_ferr++;
                if (d == 8'h00) ex_brk++;
            end
`ifdef UART_PARITY_EN
            if (pb != even_par(d)) ex_perr++;
`endif
            send_frame(d, ok, pb, BIT_NS);
            if (!ok || $urandom_range(1) == 1) idle($urandom_range(CLK_DIV, 3 * CLK_DIV));
        end
        idle(2 * CLK_DIV);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q.size() <= q0 + i || got_q[q0+i] !== exp_q[i]) mism++;
        end
        total++;
        if (n_valid - v0 != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d want %0d", n_valid - v0, exp_q.size());
        end
        total++;
        if (mism != 0) begin
            bad++; $display("FAIL rand_bytes: got %0d wrong bytes want 0", mism);
        end
        total++;
        if (n_ferr - f0 != ex_ferr || n_brk - b0 != ex_brk) begin
            bad++; $display("FAIL rand_errs: got ferr=%0d brk=%0d want %0d %0d", n_ferr - f0,
                            n_brk - b0, ex_ferr, ex_brk);
        end
        total++;
        if (n_perr - p0 != ex_perr) begin
            bad++; $display("FAIL rand_perr: got %0d want %0d", n_perr - p0, ex_perr);
        end
    endtask

    task automatic test_reset_midframe();
        int s0, v0;
        logic [7:0] d;
        d = 8'h77;
        @(negedge clk);
        s0 = n_valid + n_ferr + n_brk + n_perr;
        rx_pin = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_pin = d[i];
            #(BIT_NS);
        end
        rx_pin = d[4];
        #(BIT_NS / 2.0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rx_data !== 8'h00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_state: got data=%0h busy=%0b want 00 0", bus.rx_data,
                            bus.busy);
        end
        rst = 1'b0;
        rx_pin = 1'b1;
        idle(2 * CLK_DIV);
        total++;
        if (n_valid + n_ferr + n_brk + n_perr - s0 != 0) begin
            bad++; $display("FAIL midrst_strobes: got %0d want 0",
                            n_valid + n_ferr + n_brk + n_perr - s0);
        end
        v0 = n_valid;
        d = 8'h12;
        send_frame(d, 1'b1, even_par(d), BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_valid - v0 != 1 || bus.rx_data !== 8'h12) begin
            bad++; $display("FAIL midrst_next: got n=%0d data=%0h want 1 12", n_valid - v0,
                            bus.rx_data);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int v0, p0, vp0;
        v0 = n_valid; p0 = n_perr; vp0 = n_vp;
        @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b0, BIT_NS);
        idle(2 * CLK_DIV);
        total++;
        if (n_vp - vp0 != 1 || n_perr - p0 != 1 || n_valid - v0 != 1) begin
            bad++; $display("FAIL parity_strobe: got both=%0d perr=%0d valid=%0d want 1 1 1",
                            n_vp - vp0, n_perr - p0, n_valid - v0);
        end
        total++;
        if (bus.rx_data !== 8'h07) begin
            bad++; $display("FAIL parity_data: got %0h want 07", bus.rx_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_random();
        test_reset_midframe();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
